// File: rtl/shift_engine_pkg.sv
// Shared types for the bit-serial shift engine.
//   state_t : FSM encoding used by shift_counter_engine.
package shift_engine_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_counter_engine_down_counter_tc.sv
// Loadable down-counter with a last-step flag.
//   clk, rst : clock / async active-high reset (cnt -> 0)
//   load     : synchronous load of init (wins over en)
//   en       : decrement by one
//   init     : load value
//   cnt      : current count
//   tc       : en & (cnt == 1), i.e. this enabled edge takes the count to zero
module down_counter_tc #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] init,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= '0;
        else if (load) cnt <= init;
        else if (en)   cnt <= cnt - 1'b1;
    end

    assign tc = en && (cnt == CNT_W'(1));

endmodule

// File: rtl/shift_counter_engine.sv
// Bit-serial shift engine: a DATA_W shift register clocked for exactly `len`
// shifts by an internal down-counter, with start/done handshake and preload.
//   clk, rst            : clock / async active-high reset
//   start, len          : request a run of len shifts (sampled when ready)
//   load_data, data_in  : parallel preload (sampled when ready)
//   ser_in              : bit entering the vacated end on each shift
//   ser_out             : outgoing bit (LSB or MSB of the register)
//   data_out            : shift register contents
//   ready / busy / done : idle / running-or-finishing / one-cycle end pulse
module shift_counter_engine
    import shift_engine_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              load_data,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ser_in,
    output logic              ser_out,
    output logic [DATA_W-1:0] data_out,
    output logic              ready,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sr, sr_shifted;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_load, cnt_en, cnt_tc;

    // Zero-length runs skip the counter entirely and go straight to S_DONE.
    assign cnt_load = (state == S_IDLE) && start && (len != '0);
    // Gating on cnt != 0 keeps the counter from ever wrapping.
    assign cnt_en   = (state == S_SHIFT) && (cnt != '0);

    down_counter_tc #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .en   (cnt_en),
        .init (len),
        .cnt  (cnt),
        .tc   (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = (len != '0) ? S_SHIFT : S_DONE;
            // cnt == 0 is unreachable in S_SHIFT; treat it as finished.
            S_SHIFT: if (cnt_tc || cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    generate
        if (MSB_FIRST) begin : g_msb
            assign sr_shifted = {sr[DATA_W-2:0], ser_in};
            assign ser_out    = sr[DATA_W-1];
        end else begin : g_lsb
            assign sr_shifted = {ser_in, sr[DATA_W-1:1]};
            assign ser_out    = sr[0];
        end
    endgenerate

    // Shift only on counted edges; preload only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   sr <= '0;
        else if (state == S_IDLE && load_data)     sr <= data_in;
        else if (cnt_en)                           sr <= sr_shifted;
    end

    assign data_out = sr;
    assign ready    = (state == S_IDLE);
    assign busy     = (state == S_SHIFT) || (state == S_DONE);
    assign done     = (state == S_DONE);

endmodule
